// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO; frames are 8N1 (start 0, 8 data bits LSB first, stop 1).
// Latency: trmt sampled at edge k into an empty FIFO drives TX low after edge k+2; back-to-back frames have no idle gap.
// Backpressure: full is derived from the registered occupancy; a trmt seen while full is silently dropped.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   trmt     write strobe, queues tx_data when high and full is low
//   tx_data  byte to queue
//   TX       registered serial line, idles high
//   full     FIFO holds DEPTH bytes
//   busy     frame in progress or bytes queued (registered, aligned with TX)
//   tx_done  one-cycle pulse during the last cycle of each stop bit
module uart_tx_fifo #(
  parameter int BAUD_DIV = 2604,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       full,
  output logic       busy,
  output logic       tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  typedef enum logic {IDLE, XMIT} state_t;

  // FIFO storage: no reset, entries beyond the occupancy are don't-care
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          push, pop, empty;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  // A pop in the same cycle does not make room: full comes from the registered count
  assign push    = trmt && !full;

  assign TX      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  // Pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    pop        = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = {1'b1, mem_q[rd_ptr_q], 1'b0};
          bit_cnt_d  = 4'd0;
          baud_cnt_d = BAUD_RELOAD;
          state_d    = XMIT;
        end
      end
      XMIT: begin
        if (baud_cnt_q != 16'd0) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else if (bit_cnt_q == 4'd9) begin
          // Tenth bit period (the stop bit) has expired: the bit count would reach 10 here.
          // Reloading in this same cycle is what gives zero idle time between frames.
          done_d    = 1'b1;
          bit_cnt_d = 4'd10;
          if (!empty) begin
            pop        = 1'b1;
            shift_d    = {1'b1, mem_q[rd_ptr_q], 1'b0};
            bit_cnt_d  = 4'd0;
            baud_cnt_d = BAUD_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_d    = {1'b1, shift_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = BAUD_RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX and busy lag the FSM by one register so both line up with the serial line
  always_comb begin
    tx_d   = (state_q == XMIT) ? shift_q[0] : 1'b1;
    busy_d = (state_q == XMIT) || !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 10'h3FF;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int B  = 16;
  localparam int D  = 4;
  localparam int FR = 10 * B;
  localparam int NW = 3 * D + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX, full, busy, tx_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rx_ferr = 0;
  logic [7:0] rx_q [$];
  logic [7:0] rx_byte;
  logic [7:0] burst [4];
  logic [7:0] wr_exp [NW];

  always #5 clk = ~clk;

  uart_tx_fifo #(.BAUD_DIV(B), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .full    (full),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always @(posedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
  end

  // Loopback receiver: mid-bit sampling
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && TX === 1'b0) begin
      repeat (B/2 - 1) @(negedge clk);
      if (TX !== 1'b0) rx_ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (B) @(negedge clk);
        rx_byte[i] = TX;
      end
      repeat (B) @(negedge clk);
      if (TX !== 1'b1) rx_ferr++;
      rx_q.push_back(rx_byte);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks TX bit-by-bit and tx_done for one frame, from frame cycle 'first' to FR.
  // With poke set, a write of 0x77 is attempted in the cycle that pops the next entry.
  task automatic check_frame(input logic [7:0] d, input int first, input bit poke);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int n = first; n <= FR; n++) begin
      chk($sformatf("tx_%02h_c%0d", d, n), 32'(TX), 32'(f[(n-1)/B]));
      chk($sformatf("done_%02h_c%0d", d, n), 32'(tx_done), 32'(n == FR));
      if (poke && n == FR - 1) begin trmt = 1'b1; tx_data = 8'h77; end
      if (poke && n == FR) trmt = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int d0, idx, cyc, lowcnt;
    burst = '{8'h00, 8'hFF, 8'h55, 8'h81};
    rst_n = 1'b1; trmt = 1'b0; tx_data = 8'h00;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx", 32'(TX), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single byte 0xA5: TX low two edges after the write edge
    tx_data = 8'hA5; trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    chk("a5_busy_k", 32'(busy), 32'd0);
    chk("a5_full_k", 32'(full), 32'd0);
    @(negedge clk);
    chk("a5_tx_k1", 32'(TX), 32'd1);
    chk("a5_busy_k1", 32'(busy), 32'd1);
    @(negedge clk);
    check_frame(8'hA5, 1, 1'b0);
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_tx_end", 32'(TX), 32'd1);
    chk("a5_done_cnt", 32'(done_cnt), 32'd1);

    // Burst of four consecutive writes; first byte pops immediately, so three remain queued
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      tx_data = burst[i]; trmt = 1'b1;
      @(negedge clk);
    end
    trmt = 1'b0;
    chk("burst_full", 32'(full), 32'd0);
    chk("burst_busy", 32'(busy), 32'd1);
    check_frame(burst[0], 2, 1'b0);
    for (int i = 1; i < 4; i++) check_frame(burst[i], 1, 1'b0);
    chk("burst_busy_end", 32'(busy), 32'd0);
    chk("burst_tx_end", 32'(TX), 32'd1);
    chk("burst_dones", 32'(done_cnt - d0), 32'd4);

    // Overflow: five writes fill the FIFO (one already popped), then six writes while full
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'(8'h11 * (i + 1)); trmt = 1'b1;
      @(negedge clk);
    end
    chk("ovf_full_set", 32'(full), 32'd1);
    for (int j = 0; j < 6; j++) begin
      tx_data = 8'(8'h60 + j); trmt = 1'b1;
      @(negedge clk);
    end
    trmt = 1'b0;
    chk("ovf_full_held", 32'(full), 32'd1);
    check_frame(8'h11, 9, 1'b1);
    chk("ovf_full_drop", 32'(full), 32'd0);
    check_frame(8'h22, 1, 1'b0);
    check_frame(8'h33, 1, 1'b0);
    check_frame(8'h44, 1, 1'b0);
    check_frame(8'h55, 1, 1'b0);
    chk("ovf_busy_end", 32'(busy), 32'd0);
    repeat (2 * FR) @(negedge clk);
    chk("ovf_dones", 32'(done_cnt - d0), 32'd5);
    chk("ovf_tx_quiet", 32'(TX), 32'd1);
    chk("ovf_busy_quiet", 32'(busy), 32'd0);

    // Pointer wrap: flow-controlled writes checked through the loopback receiver
    rx_q.delete();
    rx_ferr = 0;
    idx = 0; cyc = 0;
    for (int i = 0; i < NW; i++) wr_exp[i] = 8'(i * 37 + 5);
    while (idx < NW && cyc < 20000) begin
      if (!full) begin
        tx_data = wr_exp[idx]; trmt = 1'b1; idx++;
      end else begin
        trmt = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    trmt = 1'b0;
    chk("wrap_written", 32'(idx), 32'(NW));
    cyc = 0;
    while (rx_q.size() < NW && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap_rx_count", 32'(rx_q.size()), 32'(NW));
    for (int i = 0; i < NW; i++) begin
      if (i < rx_q.size()) chk($sformatf("wrap_rx_%0d", i), 32'(rx_q[i]), 32'(wr_exp[i]));
    end
    chk("wrap_ferr", 32'(rx_ferr), 32'd0);
    repeat (B) @(negedge clk);
    chk("wrap_busy_end", 32'(busy), 32'd0);

    // Reset in the middle of data bit 4 with a second byte still queued
    tx_data = 8'hC3; trmt = 1'b1;
    @(negedge clk);
    tx_data = 8'hEE;
    @(negedge clk);
    trmt = 1'b0;
    @(negedge clk);
    repeat (87) @(negedge clk);
    chk("mid_bit4", 32'(TX), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(TX), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      if (TX !== 1'b1) lowcnt++;
      @(negedge clk);
    end
    chk("post_rst_quiet", 32'(lowcnt), 32'd0);
    chk("post_rst_dones", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    tx_data = 8'h3C; trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_frame(8'h3C, 1, 1'b0);
    chk("r3c_busy_end", 32'(busy), 32'd0);
    chk("r3c_dones", 32'(done_cnt - d0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
